bram_arbiter: RTL

BRAM_ARBITER -- requirements
Module: bram_arbiter

---
 rtl/bram_arbiter_if.sv | 42 ++++
 rtl/bram_arbiter.sv | 117 +++++++++++
 2 files changed

// File: rtl/bram_arbiter_if.sv
// rtl/bram_arbiter_if.sv - requester, memory and status signals of the two-port BRAM arbiter
interface bram_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  logic                  req0;
  logic                  we0;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [DATA_WIDTH-1:0] wdata0;
  logic                  gnt0;
  logic                  rvalid0;
  logic [DATA_WIDTH-1:0] rdata0;

  logic                  req1;
  logic                  we1;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] wdata1;
  logic                  gnt1;
  logic                  rvalid1;
  logic [DATA_WIDTH-1:0] rdata1;

  logic                  readEnable;
  logic [ADDR_WIDTH-1:0] readAddress;
  logic                  writeEnable;
  logic [ADDR_WIDTH-1:0] writeAddress;
  logic [DATA_WIDTH-1:0] writeData;
  logic [DATA_WIDTH-1:0] readData;

  logic                  busy;

  modport slave (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, readData,
    output gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1,
    output readEnable, readAddress, writeEnable, writeAddress, writeData, busy
  );

  modport master (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, readData,
    input  gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1,
    input  readEnable, readAddress, writeEnable, writeAddress, writeData, busy
  );
endinterface

// File: rtl/bram_arbiter.sv
// rtl/bram_arbiter.sv - two-port single-BRAM arbiter with burst-limited ownership
// Optional conflict counters are built when BRAM_ARB_STATS_EN is defined.
module bram_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic         clock,
  input  logic         reset,
  bram_arbiter_if.slave bus
`ifdef BRAM_ARB_STATS_EN
  ,
  output logic [15:0]  conflictCount0,
  output logic [15:0]  conflictCount1
`endif
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

  logic          owner_q, owner_d;
  logic [BW-1:0] burst_q, burst_d;
  logic          rd_pend_q, rd_pend_d;
  logic          rd_port_q, rd_port_d;

  logic                  gnt0, gnt1, any_gnt, sel, g_we;
  logic [ADDR_WIDTH-1:0] g_addr;
  logic [DATA_WIDTH-1:0] g_wdata;

  // Under contention the owner keeps the memory until its burst is used up.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      if (bus.req0 && bus.req1) begin
        if (burst_q >= BURST_MAX) begin
          gnt0 = owner_q;
          gnt1 = !owner_q;
        end else begin
          gnt0 = !owner_q;
          gnt1 = owner_q;
        end
      end else begin
        gnt0 = bus.req0;
        gnt1 = bus.req1;
      end
    end
  end

  assign any_gnt = gnt0 | gnt1;
  assign sel     = gnt1;
  assign g_we    = sel ? bus.we1    : bus.we0;
  assign g_addr  = sel ? bus.addr1  : bus.addr0;
  assign g_wdata = sel ? bus.wdata1 : bus.wdata0;

  assign bus.gnt0         = gnt0;
  assign bus.gnt1         = gnt1;
  assign bus.readEnable   = any_gnt && !g_we;
  assign bus.readAddress  = (any_gnt && !g_we) ? g_addr : '0;
  assign bus.writeEnable  = any_gnt && g_we;
  assign bus.writeAddress = (any_gnt && g_we) ? g_addr : '0;
  assign bus.writeData    = (any_gnt && g_we) ? g_wdata : '0;

  always_comb begin
    owner_d   = owner_q;
    burst_d   = burst_q;
    rd_pend_d = any_gnt && !g_we;
    rd_port_d = sel;
    if (any_gnt) begin
      owner_d = sel;
      if (sel == owner_q) begin
        burst_d = (burst_q == BURST_MAX) ? burst_q : burst_q + BW'(1);
      end else begin
        burst_d = BW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      owner_q   <= 1'b0;
      burst_q   <= '0;
      rd_pend_q <= 1'b0;
      rd_port_q <= 1'b0;
    end else begin
      owner_q   <= owner_d;
      burst_q   <= burst_d;
      rd_pend_q <= rd_pend_d;
      rd_port_q <= rd_port_d;
    end
  end

  // Read tag registered at grant lines up with the one-cycle BRAM latency.
  assign bus.rvalid0 = rd_pend_q && !rd_port_q && !reset;
  assign bus.rvalid1 = rd_pend_q && rd_port_q && !reset;
  assign bus.rdata0  = bus.rvalid0 ? bus.readData : '0;
  assign bus.rdata1  = bus.rvalid1 ? bus.readData : '0;
  assign bus.busy    = rd_pend_q && !reset;

`ifdef BRAM_ARB_STATS_EN
  logic [15:0] conf0_q, conf1_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      conf0_q <= '0;
      conf1_q <= '0;
    end else begin
      if (bus.req0 && !gnt0 && conf0_q != 16'hFFFF) conf0_q <= conf0_q + 16'd1;
      if (bus.req1 && !gnt1 && conf1_q != 16'hFFFF) conf1_q <= conf1_q + 16'd1;
    end
  end

  assign conflictCount0 = conf0_q;
  assign conflictCount1 = conf1_q;
`endif

endmodule
